// File: rtl/struct_table_sched.sv
// Round-robin shared access to a constant table of packed-struct entries;
// the granted entry is streamed word-by-word over a valid/ready port.
module struct_table_sched #(
    parameter int unsigned ENTRIES = 3,
    parameter int unsigned WORDS   = 3,
    parameter int unsigned DW      = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [1:0]                 req,
    input  logic [$clog2(ENTRIES)-1:0] req_idx0,
    input  logic [$clog2(ENTRIES)-1:0] req_idx1,
    output logic [1:0]                 done,
    output logic                       err,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DW-1:0]              out_data,
    output logic                       out_last,
    output logic                       out_src
);
    localparam int unsigned IW = $clog2(ENTRIES);
    localparam int unsigned CW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(WORDS - 1);

    typedef struct packed {
        logic [WORDS-1:0][DW-1:0] word;
    } entry_t;

    typedef enum logic {
        IDLE,
        STREAM
    } state_t;

    entry_t rom [ENTRIES];

    always_comb begin
        for (int unsigned e = 0; e < ENTRIES; e++) begin
            for (int unsigned w = 0; w < WORDS; w++) begin
                rom[e].word[w] = {4'(e + 1), (DW-4)'(w)};
            end
        end
    end

    state_t          state_q, state_d;
    logic            src_q, src_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            rr_q, rr_d;
    logic [1:0]      done_q, done_d;
    logic            err_q, err_d;
    logic            out_valid_q, out_valid_d;
    logic [DW-1:0]   out_data_q, out_data_d;
    logic            out_last_q, out_last_d;
    logic            out_src_q, out_src_d;

    logic [1:0]      eligible;
    logic            grant_src;
    logic [IW-1:0]   grant_idx;
    logic [CW-1:0]   cnt_nxt;
    entry_t          cur_entry;

    always_comb begin
        state_d     = state_q;
        src_d       = src_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        rr_d        = rr_q;
        done_d      = '0;
        err_d       = 1'b0;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        out_src_d   = out_src_q;

        // done_q masks a requester still lowering req right after its completion
        eligible  = req & ~done_q;
        grant_src = (eligible == 2'b11) ? ~rr_q : eligible[1];
        grant_idx = grant_src ? req_idx1 : req_idx0;
        cnt_nxt   = cnt_q + CW'(1);
        cur_entry = rom[idx_q];

        case (state_q)
            IDLE: begin
                if (eligible != 2'b00) begin
                    src_d = grant_src;
                    idx_d = grant_idx;
                    if (32'(grant_idx) >= 32'(ENTRIES)) begin
                        err_d             = 1'b1;
                        done_d[grant_src] = 1'b1;
                        rr_d              = grant_src;
                    end else begin
                        state_d = STREAM;
                        cnt_d   = '0;
                    end
                end
            end
            STREAM: begin
                // First cycle in STREAM loads the output register; later cycles advance on transfer
                if (!out_valid_q) begin
                    out_valid_d = 1'b1;
                    out_data_d  = cur_entry.word[cnt_q];
                    out_last_d  = (cnt_q == LAST_CNT);
                    out_src_d   = src_q;
                end else if (out_ready) begin
                    if (out_last_q) begin
                        state_d        = IDLE;
                        out_valid_d    = 1'b0;
                        out_last_d     = 1'b0;
                        done_d[src_q]  = 1'b1;
                        rr_d           = src_q;
                    end else begin
                        cnt_d      = cnt_nxt;
                        out_data_d = cur_entry.word[cnt_nxt];
                        out_last_d = (cnt_nxt == LAST_CNT);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            src_q       <= 1'b0;
            idx_q       <= '0;
            cnt_q       <= '0;
            rr_q        <= 1'b1;
            done_q      <= '0;
            err_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            out_src_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            src_q       <= src_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            rr_q        <= rr_d;
            done_q      <= done_d;
            err_q       <= err_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            out_src_q   <= out_src_d;
        end
    end

    assign done      = done_q;
    assign err       = err_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign out_src   = out_src_q;

endmodule

// File: tb/tb_struct_table_sched.sv
// Directed bench for struct_table_sched: streams, backpressure, arbitration,
// bad index and mid-stream reset, checked with immediate assertions.
module tb_struct_table_sched;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req;
    logic [1:0]  req_idx0;
    logic [1:0]  req_idx1;
    logic [1:0]  done;
    logic        err;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_last;
    logic        out_src;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    struct_table_sched #(.ENTRIES(3), .WORDS(3), .DW(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .req_idx0  (req_idx0),
        .req_idx1  (req_idx1),
        .done      (done),
        .err       (err),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_src   (out_src)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Expects the stream of entry e for requester src; rpat[n%4] drives out_ready
    // on the n-th valid cycle. Ends right after the edge carrying the last transfer.
    task automatic run_stream(input string tag, input int e, input logic src,
                              input logic [3:0] rpat, input int lat);
        int w = 0;
        int n = 0;
        int waited = 0;
        logic [31:0] exp_word;
        while (1) begin
            tick();
            waited++;
            if (out_valid) break;
            if (waited > 20) begin
                chk({tag, "_timeout"}, 64'(waited), 64'(lat));
                return;
            end
        end
        chk({tag, "_latency"}, 64'(waited), 64'(lat));
        while (w < 3) begin
            exp_word = {4'(e + 1), 28'(w)};
            chk({tag, "_valid"}, 64'(out_valid), 64'd1);
            chk({tag, "_data"},  64'(out_data),  64'(exp_word));
            chk({tag, "_last"},  64'(out_last),  64'(w == 2));
            chk({tag, "_src"},   64'(out_src),   64'(src));
            out_ready = rpat[n % 4];
            if (out_ready) w++;
            n++;
            if (w < 3) tick();
            if (n > 40) begin
                chk({tag, "_stall_timeout"}, 64'(n), 64'd0);
                return;
            end
        end
        tick();
        chk({tag, "_done"},      64'(done),      64'(2'b01 << src));
        chk({tag, "_end_valid"}, 64'(out_valid), 64'd0);
        chk({tag, "_end_err"},   64'(err),       64'd0);
    endtask

    initial begin
        rst_n = 1'b0; req = 2'b00; req_idx0 = 2'd0; req_idx1 = 2'd0; out_ready = 1'b0;
        tick(); tick();
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_done",  64'(done),      64'd0);
        chk("rst_err",   64'(err),       64'd0);
        chk("rst_data",  64'(out_data),  64'd0);
        chk("rst_last",  64'(out_last),  64'd0);
        chk("rst_src",   64'(out_src),   64'd0);
        rst_n = 1'b1;

        // 1: single request
        req = 2'b01; req_idx0 = 2'd1; out_ready = 1'b1;
        run_stream("t1", 1, 1'b0, 4'b1111, 2);
        req = 2'b00;
        tick();
        chk("t1_done_clear", 64'(done), 64'd0);

        // 2: backpressure, then requester 1 dropping req late must not be re-granted
        req = 2'b10; req_idx1 = 2'd2;
        run_stream("t2", 2, 1'b1, 4'b1001, 2);
        tick();
        req = 2'b00;
        tick();
        chk("t2_no_regrant", 64'(out_valid), 64'd0);
        tick();
        chk("t2_no_regrant2", 64'(out_valid), 64'd0);

        // 3+4: contention from reset and fairness over four streams
        rst_n = 1'b0; req = 2'b11; req_idx0 = 2'd0; req_idx1 = 2'd2;
        tick();
        rst_n = 1'b1;
        run_stream("t3_s0", 0, 1'b0, 4'b1111, 2);
        run_stream("t3_s1", 2, 1'b1, 4'b1111, 2);
        run_stream("t4_s2", 0, 1'b0, 4'b1011, 2);
        run_stream("t4_s3", 2, 1'b1, 4'b1111, 2);
        req = 2'b00;
        tick();
        chk("t4_idle", 64'(out_valid), 64'd0);

        // 5: bad index, then rr pointer favours requester 1
        req = 2'b01; req_idx0 = 2'd3;
        tick();
        chk("t5_err",   64'(err),       64'd1);
        chk("t5_done",  64'(done),      64'd1);
        chk("t5_valid", 64'(out_valid), 64'd0);
        req = 2'b00;
        tick();
        chk("t5_err_clear",  64'(err),       64'd0);
        chk("t5_done_clear", 64'(done),      64'd0);
        chk("t5_valid2",     64'(out_valid), 64'd0);
        req = 2'b11; req_idx0 = 2'd0; req_idx1 = 2'd1;
        run_stream("t5_rr", 1, 1'b1, 4'b1111, 2);
        req = 2'b00;
        tick(); tick();

        // 6: reset mid-stream, then the same request restarts from word 0
        req = 2'b01; req_idx0 = 2'd1; out_ready = 1'b1;
        tick(); tick();
        chk("t6_beat0", 64'(out_data), 64'h20000000);
        tick();
        chk("t6_beat1", 64'(out_data), 64'h20000001);
        rst_n = 1'b0;
        tick();
        chk("t6_rst_valid", 64'(out_valid), 64'd0);
        chk("t6_rst_done",  64'(done),      64'd0);
        chk("t6_rst_err",   64'(err),       64'd0);
        rst_n = 1'b1;
        run_stream("t6_restart", 1, 1'b0, 4'b1111, 2);
        req = 2'b00;
        tick(); tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
